// File: rtl/packet_width_upsizer.sv
// packet_width_upsizer: packs RATIO narrow ingress words into one wide egress
// beat. Tracks the packet byte length and the last-beat residual, flags
// protocol errors, and buffers finished beats in a first-word-fall-through
// queue.
module packet_width_upsizer #(
  parameter int IN_BYTES  = 4,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 4,
  localparam int OUT_BYTES = IN_BYTES * RATIO,
  localparam int RW        = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1,
  localparam int ORW       = $clog2(OUT_BYTES)
) (
  input  logic                   iclk,
  input  logic                   irst_n,
  input  logic                   ivalid,
  output logic                   iready,
  input  logic                   isop,
  input  logic                   ieop,
  input  logic [RW-1:0]          iresidual,
  input  logic [IN_BYTES*8-1:0]  idata,
  input  logic                   ibad,
  output logic                   ovalid,
  input  logic                   oready,
  output logic                   osop,
  output logic                   oeop,
  output logic [OUT_BYTES*8-1:0] odata,
  output logic [ORW-1:0]         oresidual,
  output logic [13:0]            oplen,
  output logic                   obad,
  output logic                   oerr
);

  localparam int IW = $clog2(RATIO);
  localparam int AW = $clog2(DEPTH);
  localparam int IB = IN_BYTES * 8;
  localparam int OB = OUT_BYTES * 8;
  // Queue entry: {sop, eop, bad, plen[13:0], residual, data}
  localparam int QW = OB + ORW + 17;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t          state_reg, state_next;
  logic [IB-1:0]   lanes_reg [RATIO];
  logic [IW-1:0]   idx_reg;
  logic [13:0]     cnt_reg;
  logic            sat_reg;
  logic            bad_reg;
  logic            first_pend_reg;
  logic            oerr_reg;

  logic [QW-1:0]   mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg;

  logic            accept, start, cont, take, err, push, pop;
  logic [15:0]     word_bytes, cnt_base, cnt_sum, res_sum;
  logic            sat_now;
  logic [13:0]     cnt_new;
  logic            beat_sop, beat_bad;
  logic [13:0]     beat_plen;
  logic [ORW-1:0]  beat_res;
  logic [OB-1:0]   beat_data;
  logic [QW-1:0]   beat_word, head_word;

  // Backpressure comes only from the registered occupancy, never from oready.
  assign iready = (count_reg < (AW+1)'(DEPTH));
  assign ovalid = (count_reg != '0);
  assign pop    = ovalid & oready;

  // Assembled beat: the lane being written takes the live word, others the gather register.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign beat_data[OB-1-gi*IB -: IB] = (idx_reg == IW'(gi)) ? idata : lanes_reg[gi];
  end

  // FSM state register.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // FSM next state: single-word packets never leave IDLE.
  always_comb begin
    state_next = state_reg;
    if (start && !ieop)     state_next = IN_PKT;
    else if (cont && ieop)  state_next = IDLE;
  end

  // FSM outputs: accept decode, error detection, byte count and beat fields.
  always_comb begin
    accept     = ivalid & iready;
    start      = accept & (state_reg == IDLE) & isop;
    cont       = accept & (state_reg == IN_PKT);
    take       = start | cont;
    err        = accept & ((state_reg == IDLE) ? ~isop : isop);
    push       = take & (ieop | (idx_reg == IW'(RATIO-1)));
    word_bytes = (ieop && iresidual != '0) ? 16'(iresidual) : 16'(IN_BYTES);
    cnt_base   = start ? 16'd0 : {2'b00, cnt_reg};
    cnt_sum    = cnt_base + word_bytes;
    sat_now    = take & (cnt_sum > 16'd16383);
    cnt_new    = sat_now ? 14'h3FFF : cnt_sum[13:0];
    res_sum    = 16'(idx_reg) * 16'(IN_BYTES) + word_bytes;
    beat_sop   = start | first_pend_reg;
    beat_bad   = ieop & ((cont & (bad_reg | sat_reg | isop)) | sat_now | ibad);
    beat_plen  = ieop ? cnt_new : 14'd0;
    beat_res   = ieop ? ORW'(res_sum % 16'(OUT_BYTES)) : '0;
    beat_word  = {beat_sop, ieop, beat_bad, beat_plen, beat_res, beat_data};
  end

  // Gather lanes, lane index, byte counter and per-packet status flags.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int i = 0; i < RATIO; i++) lanes_reg[i] <= '0;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      sat_reg        <= 1'b0;
      bad_reg        <= 1'b0;
      first_pend_reg <= 1'b0;
      oerr_reg       <= 1'b0;
    end else begin
      oerr_reg <= err;
      if (take) begin
        if (push) begin
          for (int i = 0; i < RATIO; i++) lanes_reg[i] <= '0;
          idx_reg <= '0;
        end else begin
          lanes_reg[idx_reg] <= idata;
          idx_reg            <= idx_reg + 1'b1;
        end
        cnt_reg        <= cnt_new;
        sat_reg        <= (cont & sat_reg) | sat_now;
        bad_reg        <= cont & (bad_reg | isop);
        first_pend_reg <= push ? 1'b0 : (start | first_pend_reg);
      end
    end
  end

  // Queue storage; a push can only happen while space is available.
  always_ff @(posedge iclk) begin
    if (push) mem_reg[wr_ptr_reg] <= beat_word;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head entry falls through; fields read as zero while the queue is empty.
  assign head_word = mem_reg[rd_ptr_reg];
  assign {osop, oeop, obad, oplen, oresidual, odata} = ovalid ? head_word : '0;
  assign oerr = oerr_reg;

endmodule
